// File: rtl/display_command_engine.sv
// display_command_engine
//   Command-driven drawing engine. Takes 32-bit command words over a
//   valid/ready stream. Keeps cursor, palette index and a 16-bit pattern.
//   Runs clipped rectangle fills into a framebuffer write port with
//   backpressure, and issues single-cycle palette writes.
//
// Ports
//   clk_i, reset_i         clock, synchronous active-high reset
//   control_i              [23] soft reset, [0] abort the running FILL/PAL
//   status_o               [0] busy, [1] sticky error, [4] idle,
//                          [31:16] completed-command count
//   cmd_data_i/valid/ready command stream; ready only while idle
//   fb_wr_*                pixel write request, held until fb_wr_ready_i
//   palette_wr_*           palette write strobe with entry and colour
module display_command_engine #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [31:0]                       control_i,
    output logic [31:0]                       status_o,
    input  logic [31:0]                       cmd_data_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    output logic [$clog2(RESOLUTION_X)-1:0]   fb_wr_x_o,
    output logic [$clog2(RESOLUTION_Y)-1:0]   fb_wr_y_o,
    output logic [$clog2(PALETTE_LENGTH)-1:0] fb_wr_index_o,
    output logic                              fb_wr_en_o,
    input  logic                              fb_wr_ready_i,
    output logic [$clog2(PALETTE_LENGTH)-1:0] palette_wr_index_o,
    output logic [COLOR_BITS-1:0]             palette_wr_color_o,
    output logic                              palette_wr_en_o
);
    localparam int XW = $clog2(RESOLUTION_X);
    localparam int YW = $clog2(RESOLUTION_Y);
    localparam int IW = $clog2(PALETTE_LENGTH);

    // 13 bits hold any 12-bit cursor plus any 12-bit extent without wrap.
    localparam logic [12:0] RES_X = 13'(RESOLUTION_X);
    localparam logic [12:0] RES_Y = 13'(RESOLUTION_Y);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_POS  = 4'h1;
    localparam logic [3:0] OP_IDX  = 4'h2;
    localparam logic [3:0] OP_PAT  = 4'h3;
    localparam logic [3:0] OP_FILL = 4'h4;
    localparam logic [3:0] OP_PAL  = 4'h5;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAL} state_t;

    state_t            r_state, w_next_state;
    logic [XW-1:0]     r_cur_x;
    logic [YW-1:0]     r_cur_y;
    logic [IW-1:0]     r_index;
    logic [15:0]       r_pattern;
    logic [15:0]       r_count;
    logic              r_error;
    logic [12:0]       r_x, r_y, r_x0, r_x_end, r_y_end;
    logic              r_pat_en;
    logic [IW-1:0]     r_pal_index;
    logic [COLOR_BITS-1:0] r_pal_color;

    logic        w_rst, w_accept, w_fill_empty, w_pix_on, w_adv;
    logic        w_x_wrap, w_last, w_count_inc, w_unused;
    logic [3:0]  w_op;
    logic [12:0] w_x0, w_y0, w_x_sum, w_y_sum, w_x_end, w_y_end;

    assign w_rst    = reset_i | control_i[23];
    assign w_op     = cmd_data_i[31:28];
    assign w_accept = cmd_valid_i & cmd_ready_o;

    // Fill bounds from the current cursor, clipped to the framebuffer.
    assign w_x0    = 13'(r_cur_x);
    assign w_y0    = 13'(r_cur_y);
    assign w_x_sum = w_x0 + {1'b0, cmd_data_i[11:0]};
    assign w_y_sum = w_y0 + {1'b0, cmd_data_i[23:12]};
    assign w_x_end = (w_x_sum > RES_X) ? RES_X : w_x_sum;
    assign w_y_end = (w_y_sum > RES_Y) ? RES_Y : w_y_sum;
    assign w_fill_empty = (cmd_data_i[11:0] == 12'd0) | (cmd_data_i[23:12] == 12'd0) |
                          (w_x0 >= RES_X) | (w_y0 >= RES_Y);

    // A pattern-masked pixel costs one cycle and never waits for ready.
    assign w_pix_on = ~r_pat_en | r_pattern[r_x[3:0]];
    assign w_adv    = ~w_pix_on | fb_wr_ready_i;
    assign w_x_wrap = (r_x + 13'd1 == r_x_end);
    assign w_last   = w_x_wrap & (r_y + 13'd1 == r_y_end);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_FILL && !w_fill_empty) w_next_state = S_FILL;
                    else if (w_op == OP_PAL)              w_next_state = S_PAL;
                end
            end
            S_FILL: begin
                if (control_i[0] || (w_adv && w_last)) w_next_state = S_IDLE;
            end
            S_PAL:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // A command completes when we land in IDLE having been busy, or when a
    // command is accepted that never leaves IDLE (SET_*, NOP, illegal, empty fill).
    assign w_count_inc = (w_next_state == S_IDLE) & ((r_state != S_IDLE) | w_accept);

    always_ff @(posedge clk_i) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_index     <= '0;
            r_pattern   <= 16'hFFFF;
            r_count     <= 16'd0;
            r_error     <= 1'b0;
            r_x         <= 13'd0;
            r_y         <= 13'd0;
            r_x0        <= 13'd0;
            r_x_end     <= 13'd0;
            r_y_end     <= 13'd0;
            r_pat_en    <= 1'b0;
            r_pal_index <= '0;
            r_pal_color <= '0;
        end else begin
            if (w_accept) begin
                case (w_op)
                    OP_NOP: ;
                    OP_POS: begin
                        r_cur_x <= cmd_data_i[XW-1:0];
                        r_cur_y <= cmd_data_i[12 +: YW];
                    end
                    OP_IDX: r_index   <= cmd_data_i[IW-1:0];
                    OP_PAT: r_pattern <= cmd_data_i[15:0];
                    OP_FILL: begin
                        r_x      <= w_x0;
                        r_y      <= w_y0;
                        r_x0     <= w_x0;
                        r_x_end  <= w_x_end;
                        r_y_end  <= w_y_end;
                        r_pat_en <= cmd_data_i[24];
                    end
                    OP_PAL: begin
                        r_pal_index <= cmd_data_i[16 +: IW];
                        r_pal_color <= cmd_data_i[COLOR_BITS-1:0];
                    end
                    default: r_error <= 1'b1;
                endcase
            end
            if (r_state == S_FILL && w_adv) begin
                if (w_x_wrap) begin
                    r_x <= r_x0;
                    r_y <= r_y + 13'd1;
                end else begin
                    r_x <= r_x + 13'd1;
                end
            end
            if (w_count_inc) r_count <= r_count + 16'd1;
        end
    end

    assign cmd_ready_o        = (r_state == S_IDLE);
    assign fb_wr_en_o         = (r_state == S_FILL) & w_pix_on;
    assign fb_wr_x_o          = r_x[XW-1:0];
    assign fb_wr_y_o          = r_y[YW-1:0];
    assign fb_wr_index_o      = r_index;
    assign palette_wr_en_o    = (r_state == S_PAL);
    assign palette_wr_index_o = r_pal_index;
    assign palette_wr_color_o = r_pal_color;
    assign status_o = {r_count, 11'd0, (r_state == S_IDLE), 2'd0, r_error, (r_state != S_IDLE)};

    // Command and control bits not decoded at every parameterisation.
    assign w_unused = ^{cmd_data_i, control_i};

endmodule

// File: tb/tb_display_command_engine.sv
module tb_display_command_engine;
    localparam int RX = 400;
    localparam int RY = 300;
    localparam int PL = 256;
    localparam int CB = 12;
    localparam int XW = $clog2(RX);
    localparam int YW = $clog2(RY);
    localparam int IW = $clog2(PL);

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [31:0]   control_i = 32'd0;
    logic [31:0]   status_o;
    logic [31:0]   cmd_data_i = 32'd0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [XW-1:0] fb_wr_x_o;
    logic [YW-1:0] fb_wr_y_o;
    logic [IW-1:0] fb_wr_index_o;
    logic          fb_wr_en_o;
    logic          fb_wr_ready_i;
    logic [IW-1:0] palette_wr_index_o;
    logic [CB-1:0] palette_wr_color_o;
    logic          palette_wr_en_o;

    logic man_rdy = 1'b1;
    logic rand_rdy = 1'b0;
    logic rnd_bit = 1'b1;
    assign fb_wr_ready_i = rand_rdy ? rnd_bit : man_rdy;

    typedef struct { int x; int y; int idx; int cyc; } pix_t;
    typedef struct { int idx; int col; int cyc; } pal_t;
    pix_t got[$];
    pix_t exp_q[$];
    pal_t pal_got[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cx, m_cy, m_idx, m_cnt, m_err, m_pidx, m_pcol;
    logic [15:0] m_pat;

    display_command_engine #(
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .COLOR_BITS(CB)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .control_i(control_i), .status_o(status_o),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .fb_wr_x_o(fb_wr_x_o), .fb_wr_y_o(fb_wr_y_o), .fb_wr_index_o(fb_wr_index_o),
        .fb_wr_en_o(fb_wr_en_o), .fb_wr_ready_i(fb_wr_ready_i),
        .palette_wr_index_o(palette_wr_index_o), .palette_wr_color_o(palette_wr_color_o),
        .palette_wr_en_o(palette_wr_en_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 2) != 0);
    end

    // Handshake monitor: inputs are driven just after posedge, so at negedge
    // the en/ready pair is exactly what the next edge will sample.
    always @(negedge clk) begin
        if (fb_wr_en_o && fb_wr_ready_i)
            got.push_back('{int'(fb_wr_x_o), int'(fb_wr_y_o), int'(fb_wr_index_o), cyc});
        if (palette_wr_en_o)
            pal_got.push_back('{int'(palette_wr_index_o), int'(palette_wr_color_o), cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_cx = 0; m_cy = 0; m_idx = 0; m_cnt = 0; m_err = 0;
        m_pidx = 0; m_pcol = 0; m_pat = 16'hFFFF;
    endfunction

    // Command semantics; for FILL builds the list of expected writes, each
    // stamped with the cycle it appears in when the framebuffer never stalls.
    function automatic void model_apply(input logic [31:0] w, input int acc);
        int op, xe, ye, pos;
        op = int'(w[31:28]);
        m_cnt = (m_cnt + 1) % 65536;
        case (op)
            0: ;
            1: begin
                m_cx = int'(w[11:0]) % (1 << XW);
                m_cy = int'(w[23:12]) % (1 << YW);
            end
            2: m_idx = int'(w[7:0]) % (1 << IW);
            3: m_pat = w[15:0];
            4: begin
                exp_q.delete();
                xe = m_cx + int'(w[11:0]); if (xe > RX) xe = RX;
                ye = m_cy + int'(w[23:12]); if (ye > RY) ye = RY;
                pos = 0;
                for (int y = m_cy; y < ye; y++)
                    for (int x = m_cx; x < xe; x++) begin
                        if (!w[24] || m_pat[x % 16]) exp_q.push_back('{x, y, m_idx, acc + 1 + pos});
                        pos++;
                    end
            end
            5: begin
                m_pidx = int'(w[27:16]) % (1 << IW);
                m_pcol = int'(w[15:0]) % (1 << CB);
            end
            default: m_err = 1;
        endcase
    endfunction

    task automatic send_cmd(input logic [31:0] w, output int acc);
        int t;
        t = 0;
        cmd_data_i = w;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && t < 3000) begin tick(); t++; end
        checks++;
        if (!cmd_ready_o) begin
            errors++;
            $display("FAIL send_cmd: cmd_ready_o=%0b want 1 within 3000 cycles", cmd_ready_o);
        end
        acc = cyc;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_cmd(input logic [31:0] w, output int acc);
        send_cmd(w, acc);
        model_apply(w, acc);
    endtask

    task automatic wait_ready(input int limit, output int at);
        int t;
        t = 0;
        while (!cmd_ready_o && t < limit) begin tick(); t++; end
        at = cyc;
        checks++;
        if (!cmd_ready_o) begin
            errors++;
            $display("FAIL wait_ready: still busy after %0d cycles", limit);
        end
    endtask

    function automatic logic [31:0] c_pos(input int x, input int y);
        return {4'h1, 4'h0, 12'(y), 12'(x)};
    endfunction
    function automatic logic [31:0] c_fill(input int w, input int h, input bit pe);
        return {4'h4, 3'b0, pe, 12'(h), 12'(w)};
    endfunction

    task automatic test_reset();
        int acc, at, n0;
        reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
        model_reset();
        checks++; if (status_o !== 32'h10) begin errors++; $display("FAIL reset_status got %h want 00000010", status_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready_o); end
        checks++; if ({fb_wr_en_o, palette_wr_en_o} !== 2'b00) begin errors++; $display("FAIL reset_en got %b%b want 00", fb_wr_en_o, palette_wr_en_o); end
        checks++;
        if ({fb_wr_x_o, fb_wr_y_o, fb_wr_index_o, palette_wr_index_o, palette_wr_color_o} !== '0) begin
            errors++; $display("FAIL reset_data got x%0d y%0d i%0d pi%0d pc%0d want 0", fb_wr_x_o, fb_wr_y_o, fb_wr_index_o, palette_wr_index_o, palette_wr_color_o);
        end
        do_cmd(c_pos(5, 7), acc);
        do_cmd(32'h2000_003A, acc);
        n0 = got.size();
        do_cmd(c_fill(2, 2, 1'b0), acc);
        wait_ready(200, at);
        checks++; if (at !== acc + 5) begin errors++; $display("FAIL basic_ready_cycle got %0d want %0d", at - acc, 5); end
        checks++; if (got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL basic_writes got %0d want %0d", got.size() - n0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0+i].x !== exp_q[i].x || got[n0+i].y !== exp_q[i].y || got[n0+i].idx !== exp_q[i].idx || got[n0+i].cyc !== exp_q[i].cyc) begin
                errors++; $display("FAIL basic_pix[%0d] got (%0d,%0d,i%0d,c%0d) want (%0d,%0d,i%0d,c%0d)", i,
                    got[n0+i].x, got[n0+i].y, got[n0+i].idx, got[n0+i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].idx, exp_q[i].cyc);
            end
        end
        checks++; if (int'(status_o[31:16]) !== m_cnt) begin errors++; $display("FAIL basic_count got %0d want %0d", status_o[31:16], m_cnt); end
    endtask

    task automatic test_clip();
        int acc, at, n0;
        do_cmd(c_pos(398, 299), acc);
        n0 = got.size();
        do_cmd(c_fill(10, 10, 1'b0), acc);
        wait_ready(200, at);
        checks++; if (got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL clip_writes got %0d want %0d", got.size() - n0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0+i].x !== exp_q[i].x || got[n0+i].y !== exp_q[i].y || got[n0+i].cyc !== exp_q[i].cyc) begin
                errors++; $display("FAIL clip_pix[%0d] got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", i,
                    got[n0+i].x, got[n0+i].y, got[n0+i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].cyc);
            end
        end
        checks++; if (at !== acc + 1 + exp_q.size()) begin errors++; $display("FAIL clip_ready_cycle got %0d want %0d", at - acc, 1 + exp_q.size()); end
        do_cmd(c_pos(400, 0), acc);
        n0 = got.size();
        do_cmd(c_fill(5, 5, 1'b0), acc);
        checks++; if (cmd_ready_o !== 1'b1 || status_o[0] !== 1'b0) begin errors++; $display("FAIL clip_empty_idle got ready=%b busy=%b want 1/0", cmd_ready_o, status_o[0]); end
        tick(); tick();
        checks++; if (got.size() !== n0) begin errors++; $display("FAIL clip_empty_writes got %0d want 0", got.size() - n0); end
    endtask

    task automatic test_backpressure();
        int acc, at, n0;
        do_cmd(c_pos(10, 20), acc);
        man_rdy = 1'b1;
        n0 = got.size();
        do_cmd(c_fill(3, 1, 1'b0), acc);
        tick();
        man_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fb_wr_en_o !== 1'b1 || int'(fb_wr_x_o) !== 11 || int'(fb_wr_y_o) !== 20 || int'(fb_wr_index_o) !== m_idx) begin
                errors++; $display("FAIL bp_hold[%0d] got en=%b (%0d,%0d,i%0d) want en=1 (11,20,i%0d)", k, fb_wr_en_o, fb_wr_x_o, fb_wr_y_o, fb_wr_index_o, m_idx);
            end
            tick();
        end
        man_rdy = 1'b1;
        wait_ready(200, at);
        checks++; if (got.size() - n0 !== 3) begin errors++; $display("FAIL bp_handshakes got %0d want 3", got.size() - n0); end
        for (int i = 0; i < 3 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0+i].x !== exp_q[i].x || got[n0+i].y !== exp_q[i].y || got[n0+i].idx !== exp_q[i].idx) begin
                errors++; $display("FAIL bp_pix[%0d] got (%0d,%0d,i%0d) want (%0d,%0d,i%0d)", i,
                    got[n0+i].x, got[n0+i].y, got[n0+i].idx, exp_q[i].x, exp_q[i].y, exp_q[i].idx);
            end
        end
        checks++; if (at !== acc + 8) begin errors++; $display("FAIL bp_ready_cycle got %0d want 8", at - acc); end
    endtask

    task automatic test_pattern();
        int acc, at, n0;
        do_cmd(32'h3000_5555, acc);
        do_cmd(c_pos(0, 0), acc);
        n0 = got.size();
        do_cmd(c_fill(16, 1, 1'b1), acc);
        wait_ready(200, at);
        checks++; if (got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL pat_writes got %0d want %0d", got.size() - n0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0+i].x !== exp_q[i].x || got[n0+i].cyc !== exp_q[i].cyc) begin
                errors++; $display("FAIL pat_pix[%0d] got x%0d c%0d want x%0d c%0d", i, got[n0+i].x, got[n0+i].cyc, exp_q[i].x, exp_q[i].cyc);
            end
        end
        checks++; if (at !== acc + 17) begin errors++; $display("FAIL pat_duration got %0d want 17", at - acc); end
    endtask

    task automatic test_palette();
        int acc, n0;
        n0 = pal_got.size();
        do_cmd(32'h5012_0ABC, acc);
        checks++;
        if (cmd_ready_o !== 1'b0 || palette_wr_en_o !== 1'b1 || int'(palette_wr_index_o) !== m_pidx || int'(palette_wr_color_o) !== m_pcol) begin
            errors++; $display("FAIL pal_strobe got rdy=%b en=%b i%h c%h want rdy=0 en=1 i%h c%h", cmd_ready_o, palette_wr_en_o, palette_wr_index_o, palette_wr_color_o, m_pidx, m_pcol);
        end
        tick();
        checks++; if (cmd_ready_o !== 1'b1 || palette_wr_en_o !== 1'b0) begin errors++; $display("FAIL pal_after got rdy=%b en=%b want 1/0", cmd_ready_o, palette_wr_en_o); end
        tick();
        checks++; if (pal_got.size() - n0 !== 1) begin errors++; $display("FAIL pal_strobes got %0d want 1", pal_got.size() - n0); end
        checks++; if (int'(status_o[31:16]) !== m_cnt) begin errors++; $display("FAIL pal_count got %0d want %0d", status_o[31:16], m_cnt); end
    endtask

    task automatic test_random();
        int acc, at, n0, p0, x, y;
        for (int it = 0; it < 25; it++) begin
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(380, 420) : $urandom_range(0, 30);
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(285, 310) : $urandom_range(0, 30);
            do_cmd(c_pos(x, y), acc);
            do_cmd({4'h2, 20'd0, 8'($urandom)}, acc);
            do_cmd({4'h3, 12'd0, 16'($urandom)}, acc);
            n0 = got.size();
            rand_rdy = 1'b1;
            do_cmd(c_fill($urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom)), acc);
            wait_ready(2000, at);
            rand_rdy = 1'b0;
            checks++; if (got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_writes got %0d want %0d", it, got.size() - n0, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
                checks++;
                if (got[n0+i].x !== exp_q[i].x || got[n0+i].y !== exp_q[i].y || got[n0+i].idx !== exp_q[i].idx) begin
                    errors++; $display("FAIL rnd%0d_pix[%0d] got (%0d,%0d,i%0d) want (%0d,%0d,i%0d)", it, i,
                        got[n0+i].x, got[n0+i].y, got[n0+i].idx, exp_q[i].x, exp_q[i].y, exp_q[i].idx);
                end
            end
            p0 = pal_got.size();
            do_cmd({4'h5, 12'($urandom), 16'($urandom)}, acc);
            tick();
            checks++;
            if (pal_got.size() - p0 !== 1 || pal_got[pal_got.size()-1].idx !== m_pidx || pal_got[pal_got.size()-1].col !== m_pcol) begin
                errors++; $display("FAIL rnd%0d_pal got n=%0d want 1 entry i%h c%h", it, pal_got.size() - p0, m_pidx, m_pcol);
            end
            checks++; if (int'(status_o[31:16]) !== m_cnt) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, status_o[31:16], m_cnt); end
        end
        man_rdy = 1'b1;
    endtask

    task automatic test_illegal_abort();
        int acc, n0, n1;
        do_cmd(32'hF000_0000, acc);
        checks++; if (status_o[1] !== 1'b1 || int'(status_o[31:16]) !== m_cnt || cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL illegal got err=%b cnt=%0d rdy=%b want 1/%0d/1", status_o[1], status_o[31:16], cmd_ready_o, m_cnt);
        end
        do_cmd(c_pos(0, 0), acc);
        n0 = got.size();
        do_cmd(c_fill(100, 100, 1'b0), acc);
        tick(); tick(); tick(); tick();
        control_i = 32'h1;
        tick();
        control_i = 32'h0;
        checks++; if (status_o[0] !== 1'b0 || status_o[4] !== 1'b1 || fb_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b idle=%b en=%b want 0/1/0", status_o[0], status_o[4], fb_wr_en_o);
        end
        checks++; if (status_o[1] !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", status_o[1]); end
        checks++; if (int'(status_o[31:16]) !== m_cnt) begin errors++; $display("FAIL abort_count got %0d want %0d", status_o[31:16], m_cnt); end
        checks++; if (got.size() <= n0 || got[n0].x !== exp_q[0].x || got[n0].y !== exp_q[0].y) begin
            errors++; $display("FAIL abort_first got n=%0d want first pixel (%0d,%0d)", got.size() - n0, exp_q[0].x, exp_q[0].y);
        end
        n1 = got.size();
        tick(); tick(); tick();
        checks++; if (got.size() !== n1) begin errors++; $display("FAIL abort_no_more got %0d extra want 0", got.size() - n1); end
    endtask

    task automatic test_soft_reset();
        int acc, at, n0;
        do_cmd(c_pos(50, 60), acc);
        do_cmd(32'h2000_0077, acc);
        do_cmd(c_fill(100, 100, 1'b0), acc);
        tick(); tick();
        control_i = 32'h0080_0000;
        tick();
        control_i = 32'h0;
        model_reset();
        checks++; if (status_o !== 32'h10) begin errors++; $display("FAIL soft_status got %h want 00000010", status_o); end
        checks++; if (cmd_ready_o !== 1'b1 || fb_wr_en_o !== 1'b0 || palette_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL soft_outputs got rdy=%b en=%b pen=%b want 1/0/0", cmd_ready_o, fb_wr_en_o, palette_wr_en_o);
        end
        n0 = got.size();
        do_cmd(c_fill(2, 1, 1'b0), acc);
        wait_ready(200, at);
        checks++; if (got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL soft_writes got %0d want %0d", got.size() - n0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0+i].x !== exp_q[i].x || got[n0+i].y !== exp_q[i].y || got[n0+i].idx !== exp_q[i].idx) begin
                errors++; $display("FAIL soft_pix[%0d] got (%0d,%0d,i%0d) want (%0d,%0d,i%0d)", i,
                    got[n0+i].x, got[n0+i].y, got[n0+i].idx, exp_q[i].x, exp_q[i].y, exp_q[i].idx);
            end
        end
        checks++; if (int'(status_o[31:16]) !== m_cnt) begin errors++; $display("FAIL soft_count got %0d want %0d", status_o[31:16], m_cnt); end
    endtask

    initial begin
        test_reset();
        test_clip();
        test_backpressure();
        test_pattern();
        test_palette();
        test_random();
        test_illegal_abort();
        test_soft_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
